// File: rtl/fft_uart_packetizer.sv
// Frame packetizer for uart_tx: header, FFT words MSB-first, XOR checksum.
// One byte per o_Tx_DV pulse, paced by uart_tx's done strobe.
module fft_uart_packetizer #(
    parameter int         NUM_WORDS   = 8,
    parameter int         WORD_BITS   = 16,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic                           i_Clock,
    input  logic                           i_Rst_n,
    input  logic                           i_Frame_DV,
    input  logic [NUM_WORDS*WORD_BITS-1:0] i_Frame_Data,
    output logic                           o_Ready,
    output logic                           o_Tx_DV,
    output logic [7:0]                     o_Tx_Data,
    input  logic                           i_Tx_Done,
    output logic                           o_Frame_Done,
    output logic                           o_Overrun
);

    localparam int FRAME_BITS = NUM_WORDS * WORD_BITS;
    localparam int BPW        = WORD_BITS / 8;
    localparam int DATA_BYTES = NUM_WORDS * BPW;
    localparam int TOTAL      = DATA_BYTES + 2;
    localparam int CW         = $clog2(TOTAL);
    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t                state;
    logic [FRAME_BITS-1:0] frame_buf;
    logic [CW-1:0]         byte_cnt;
    logic [CW-1:0]         nxt_cnt;
    logic [7:0]            checksum;
    logic [7:0]            nxt_byte;
    int                    data_idx;
    int                    bit_off;

    // Byte to present after the current one; index 0 is the header.
    always_comb begin
        nxt_cnt  = byte_cnt + 1'b1;
        data_idx = int'(nxt_cnt) - 1;
        bit_off  = 0;
        if (data_idx >= 0 && data_idx < DATA_BYTES)
            bit_off = (data_idx / BPW) * WORD_BITS
                    + (BPW - 1 - (data_idx % BPW)) * 8;
        if (nxt_cnt == LAST)
            nxt_byte = checksum;
        else
            nxt_byte = frame_buf[bit_off +: 8];
    end

    assign o_Ready = (state == IDLE);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state        <= IDLE;
            frame_buf    <= '0;
            byte_cnt     <= '0;
            checksum     <= '0;
            o_Tx_DV      <= 1'b0;
            o_Tx_Data    <= 8'h00;
            o_Frame_Done <= 1'b0;
            o_Overrun    <= 1'b0;
        end else begin
            o_Overrun    <= i_Frame_DV && (state != IDLE);
            o_Tx_DV      <= 1'b0;
            o_Frame_Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_Frame_DV) begin
                        frame_buf <= i_Frame_Data;
                        byte_cnt  <= '0;
                        checksum  <= '0;
                        o_Tx_Data <= HEADER_BYTE;
                        o_Tx_DV   <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (byte_cnt != '0 && byte_cnt != LAST)
                        checksum <= checksum ^ o_Tx_Data;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        if (byte_cnt == LAST) begin
                            o_Frame_Done <= 1'b1;
                            state        <= FINISH;
                        end else begin
                            byte_cnt  <= nxt_cnt;
                            o_Tx_Data <= nxt_byte;
                            o_Tx_DV   <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_uart_packetizer.sv
// Directed bench for fft_uart_packetizer with a 10-cycle uart_tx model.
// Covers framing, checksum, latency, overrun, mid-frame reset, stray done.
module tb_fft_uart_packetizer;

    localparam int NW    = 8;
    localparam int WB    = 16;
    localparam int TOTAL = 18;

    logic              tb_i_Clock_8bit = 1'b0;
    logic              i_Rst_n;
    logic              i_Frame_DV;
    logic [NW*WB-1:0]  i_Frame_Data;
    logic              o_Ready;
    logic              o_Tx_DV;
    logic [7:0]        o_Tx_Data;
    logic              i_Tx_Done;
    logic              o_Frame_Done;
    logic              o_Overrun;

    int                n_chk  = 0;
    int                n_fail = 0;
    int                stray_dv;
    logic [7:0]        got [TOTAL];
    logic [7:0]        expb[TOTAL];
    logic [NW*WB-1:0]  f1, f2, f3, alt;

    fft_uart_packetizer dut (
        .i_Clock      (tb_i_Clock_8bit),
        .i_Rst_n      (i_Rst_n),
        .i_Frame_DV   (i_Frame_DV),
        .i_Frame_Data (i_Frame_Data),
        .o_Ready      (o_Ready),
        .o_Tx_DV      (o_Tx_DV),
        .o_Tx_Data    (o_Tx_Data),
        .i_Tx_Done    (i_Tx_Done),
        .o_Frame_Done (o_Frame_Done),
        .o_Overrun    (o_Overrun)
    );

    always #5 tb_i_Clock_8bit = ~tb_i_Clock_8bit;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_i_Clock_8bit);
        #1;
    endtask

    task automatic build(input logic [NW*WB-1:0] d);
        logic [7:0] cks;
        logic [7:0] b;
        cks     = 8'h00;
        expb[0] = 8'hA5;
        for (int j = 0; j < 2 * NW; j++) begin
            b         = d[(j / 2) * WB + ((j % 2 == 0) ? 8 : 0) +: 8];
            expb[j+1] = b;
            cks       = cks ^ b;
        end
        expb[TOTAL-1] = cks;
    endtask

    task automatic compare(input string tag, input int n);
        for (int j = 0; j < n; j++)
            chk($sformatf("%s_byte%0d", tag, j), got[j], expb[j]);
    endtask

    task automatic start_frame(input logic [NW*WB-1:0] d);
        for (int t = 0; t < 100 && !o_Ready; t++) tick();
        chk("ready_before_frame", o_Ready, 1);
        i_Frame_DV   = 1'b1;
        i_Frame_Data = d;
        tick();
        i_Frame_DV   = 1'b0;
        i_Frame_Data = ~d;
        chk("first_dv_latency", o_Tx_DV, 1);
        chk("ready_busy", o_Ready, 0);
    endtask

    // uart_tx model: done pulse 10 cycles after each o_Tx_DV.
    task automatic run_bytes(input int first, input int ovr_at,
                             input int rst_at);
        stray_dv = 0;
        for (int i = first; i < TOTAL; i++) begin
            chk($sformatf("dv_at_byte%0d", i), o_Tx_DV, 1);
            got[i] = o_Tx_Data;
            tick();
            chk("dv_single_cycle", o_Tx_DV, 0);
            chk("data_hold", o_Tx_Data, got[i]);
            for (int w = 1; w <= 8; w++) begin
                if (i == ovr_at && w == 3) begin
                    i_Frame_DV   = 1'b1;
                    i_Frame_Data = alt;
                end
                if (i == rst_at && w == 5) begin
                    #2 i_Rst_n = 1'b0;
                    #1;
                    chk("rst_tx_dv", o_Tx_DV, 0);
                    chk("rst_tx_data", o_Tx_Data, 8'h00);
                    chk("rst_ready", o_Ready, 1);
                    chk("rst_frame_done", o_Frame_Done, 0);
                    chk("rst_overrun", o_Overrun, 0);
                    tick();
                    i_Tx_Done = 1'b1;
                    tick();
                    tick();
                    i_Tx_Done = 1'b0;
                    tick();
                    i_Rst_n = 1'b1;
                    for (int t = 0; t < 30; t++) begin
                        tick();
                        if (o_Tx_DV) stray_dv++;
                    end
                    chk("rst_no_more_dv", stray_dv, 0);
                    chk("rst_ready_after", o_Ready, 1);
                    return;
                end
                tick();
                if (o_Tx_DV) stray_dv++;
                if (i == ovr_at && w == 3) begin
                    i_Frame_DV = 1'b0;
                    chk("overrun_pulse", o_Overrun, 1);
                end
                if (i == ovr_at && w == 4)
                    chk("overrun_clear", o_Overrun, 0);
            end
            i_Tx_Done = 1'b1;
            tick();
            i_Tx_Done = 1'b0;
            if (i == TOTAL - 1) begin
                chk("frame_done_pulse", o_Frame_Done, 1);
                chk("ready_in_finish", o_Ready, 0);
                tick();
                chk("frame_done_clear", o_Frame_Done, 0);
                chk("ready_after_finish", o_Ready, 1);
            end
        end
        chk("no_dv_while_waiting", stray_dv, 0);
    endtask

    initial begin
        i_Rst_n      = 1'b0;
        i_Frame_DV   = 1'b0;
        i_Frame_Data = '0;
        i_Tx_Done    = 1'b0;
        for (int k = 0; k < NW; k++) begin
            f1[k*WB +: WB] = 16'(k + 1);
            f2[k*WB +: WB] = 16'hFFFF;
            f3[k*WB +: WB] = 16'hA0B0 + 16'(k);
        end

        repeat (3) tick();
        chk("reset_ready", o_Ready, 1);
        chk("reset_tx_dv", o_Tx_DV, 0);
        chk("reset_tx_data", o_Tx_Data, 8'h00);
        chk("reset_frame_done", o_Frame_Done, 0);
        chk("reset_overrun", o_Overrun, 0);
        i_Rst_n = 1'b1;
        tick();

        // Stray done strobes while idle.
        stray_dv  = 0;
        i_Tx_Done = 1'b1;
        repeat (3) begin
            tick();
            if (o_Tx_DV) stray_dv++;
        end
        i_Tx_Done = 1'b0;
        tick();
        chk("idle_done_no_dv", stray_dv, 0);
        chk("idle_done_ready", o_Ready, 1);

        // Counting words.
        build(f1);
        start_frame(f1);
        run_bytes(0, -1, -1);
        compare("f1", TOTAL);
        chk("f1_checksum", got[TOTAL-1], 8'h08);

        // All-ones words with done held high for three cycles.
        build(f2);
        start_frame(f2);
        got[0] = o_Tx_Data;
        tick();
        chk("held_wait_dv0", o_Tx_DV, 0);
        i_Tx_Done = 1'b1;
        tick();
        chk("held_adv1_dv", o_Tx_DV, 1);
        got[1] = o_Tx_Data;
        tick();
        chk("held_issue_dv0", o_Tx_DV, 0);
        tick();
        chk("held_adv2_dv", o_Tx_DV, 1);
        i_Tx_Done = 1'b0;
        run_bytes(2, -1, -1);
        compare("f2", TOTAL);
        chk("f2_header", got[0], 8'hA5);
        chk("f2_checksum", got[TOTAL-1], 8'h00);

        // Overrun during byte 5; frame must be unaffected.
        alt = f2;
        build(f1);
        start_frame(f1);
        run_bytes(0, 5, -1);
        compare("ovr", TOTAL);
        stray_dv = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (o_Tx_DV) stray_dv++;
        end
        chk("ovr_no_second_frame", stray_dv, 0);

        // Reset while waiting on byte 7, then a fresh frame.
        build(f3);
        start_frame(f3);
        run_bytes(0, -1, 7);
        compare("pre_rst", 8);
        start_frame(f3);
        run_bytes(0, -1, -1);
        compare("post_rst", TOTAL);
        chk("post_rst_header", got[0], 8'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_uart_packetizer.md
Name: fft_uart_packetizer

Overview:
Sits directly upstream of uart_tx and drives its i_Tx_DV/i_Tx_Data handshake. It captures one complete FFT output frame (NUM_WORDS words) in a single cycle and sends it as a framed byte stream through uart_tx. The stream is a header byte, then the data bytes, then an XOR checksum byte. It paces each byte on uart_tx's o_Tx_Done, so the FFT core never has to track serial timing.

Parameters:
NUM_WORDS, 8, words per frame (FFT points); must be ≥1
WORD_BITS, 16, bits per word; must be a multiple of 8
HEADER_BYTE, 8'hA5, sync byte sent first in every frame

Ports:
i_Clock  input  1  system clock; all logic on rising edge
i_Rst_n  input  1  asynchronous active-low reset
i_Frame_DV  input  1  one-cycle pulse: i_Frame_Data holds a valid frame
i_Frame_Data  input  NUM_WORDS*WORD_BITS  word k = bits [WORD_BITS*(k+1)-1 : WORD_BITS*k]
o_Ready  output  1  high only in IDLE; frame accepted this cycle if i_Frame_DV=1
o_Tx_DV  output  1  to uart_tx i_Tx_DV; one-cycle pulse per byte
o_Tx_Data  output  8  to uart_tx i_Tx_Data; valid when o_Tx_DV=1
i_Tx_Done  input  1  from uart_tx o_Tx_Done; one-cycle pulse at end of each byte
o_Frame_Done  output  1  one-cycle pulse after the last byte's i_Tx_Done
o_Overrun  output  1  one-cycle pulse when i_Frame_DV arrives while not ready

Behaviour:
- Reset (async assert, sync release):
  - State=IDLE; o_Ready=1; o_Tx_DV=0; o_Tx_Data=8'h00; o_Frame_Done=0; o_Overrun=0.
  - Frame buffer, byte counter and checksum are cleared.
- Byte sequence: total bytes TOTAL = 2 + NUM_WORDS*WORD_BITS/8 (18 at defaults).
  - Byte 0 is HEADER_BYTE.
  - Data bytes follow: word 0 first, most-significant byte of each word first.
  - The last byte is the checksum: the XOR of all data bytes, header excluded.
- State machine: IDLE, ISSUE, WAIT_DONE, FINISH.
  - IDLE: on i_Frame_DV=1, latch i_Frame_Data, clear the byte counter and checksum, go to ISSUE.
  - ISSUE: drive o_Tx_DV=1 for exactly one cycle with the current byte on o_Tx_Data. XOR the byte into the checksum if it is a data byte. Go to WAIT_DONE.
  - WAIT_DONE: o_Tx_DV=0; o_Tx_Data holds its value. On i_Tx_Done=1:
    - if counter = TOTAL-1, go to FINISH;
    - otherwise increment the counter and go to ISSUE.
  - FINISH: o_Frame_Done=1 for one cycle, go to IDLE.
- Latency:
  - Frame accepted in cycle N → first o_Tx_DV in cycle N+1.
  - i_Tx_Done in cycle M → next o_Tx_DV in cycle M+1.
  - Last i_Tx_Done in cycle M → o_Frame_Done in cycle M+1; o_Ready=1 from M+2.
- Wait time: WAIT_DONE has no timeout and waits indefinitely for i_Tx_Done.
- Ignored inputs:
  - i_Tx_Done outside WAIT_DONE is ignored.
  - i_Tx_Done held high for several cycles advances only on a cycle spent in WAIT_DONE, since ISSUE always intervenes between bytes.
- Overrun: i_Frame_DV while o_Ready=0 (ISSUE, WAIT_DONE or FINISH) is dropped.
  - o_Overrun pulses in the next cycle.
  - The frame in flight is unaffected; the buffer is not overwritten.
- Frame latching: input data is sampled only on the accept cycle; later changes to i_Frame_Data have no effect.
- Reset mid-frame: everything returns immediately to reset values and no further o_Tx_DV is issued. The byte already inside uart_tx is not the packetizer's concern.
- Width rules:
  - The byte counter is sized to hold TOTAL-1.
  - Byte extraction uses the counter minus 1 as the data byte index.
  - The checksum register is 8 bits.

Test Plan:
- Words 16'h0001..16'h0008 (word k = k+1), uart_tx model returns i_Tx_Done 10 cycles after each o_Tx_DV → bytes A5 00 01 00 02 00 03 00 04 00 05 00 06 00 07 00 08, then checksum 08; 18 o_Tx_DV pulses; one o_Frame_Done.
- Words all 16'hFFFF → 16 bytes FF, checksum 00; header A5 first; o_Tx_DV never high two consecutive cycles.
- Frame accepted at cycle N → o_Tx_DV at N+1; i_Tx_Done at cycle M → next o_Tx_DV exactly at M+1; o_Frame_Done at last-done+1; o_Ready=1 the cycle after.
- i_Frame_DV pulsed during byte 5 with different data → o_Overrun one-cycle pulse next cycle; the original frame completes unchanged; no second frame is sent.
- i_Rst_n low while waiting on byte 7 → all outputs at reset values immediately; no further o_Tx_DV; a new frame after release starts with A5.
- Spurious i_Tx_Done in IDLE, and i_Tx_Done held high 3 cycles → no o_Tx_DV from IDLE; at most one byte advance per ISSUE/WAIT_DONE pair.
